md_unit: RTL
============

// Module: md_unit
// PURPOSE
//  Parametrised multiply/divide unit with HI/LO registers for the 5-stage MIPS pipeline; sits in EX beside ALU.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX pipeline register.
//  Models configurable multi-cycle latency through a busy counter; the hazard controller stalls ID on (start|busy).
//  Generalises the fixed 32-bit ALU path in width and latency and adds abort on flush.
// PARAMETERS
//  WIDTH    32  operand / HI / LO width
//  MUL_LAT  5   cycles busy after a multiply start (>=1)
//  DIV_LAT  10  cycles busy after a divide start (>=1)
// PORTS
//  clk       in   1      clock, all state on posedge
//  reset     in   1      asynchronous, active-low; clears all state
//  start     in   1      op valid this cycle (EX stage instruction is MD-class)
//  md_op     in   3      0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 rsvd(=NOP)
//  operand1  in   WIDTH  rs value (forwarded)
//  operand2  in   WIDTH  rt value (forwarded)
//  flush     in   1      abort in-flight op (exception/branch kill)
//  busy      out  1      computation in flight; HI/LO not yet final
//  hi        out  WIDTH  HI register (MFHI source)
//  lo        out  WIDTH  LO register (MFLO source)
// BEHAVIOUR
//  Reset (reset==0, any time, async): hi=0, lo=0, busy=0, counter=0, pending results discarded.
//  States: IDLE (cnt==0), RUN (cnt>0). busy = (cnt!=0), registered.
//  IDLE + start + md_op in {1..4} at edge N: compute full result into pending_hi/pending_lo,
//    cnt <= MUL_LAT (ops 1,2) or DIV_LAT (ops 3,4). busy=1 during cycles N+1..N+LAT.
//  RUN: cnt decrements each edge; on the edge where cnt goes 1->0, hi/lo <= pending; busy falls same edge.
//    New hi/lo visible from cycle N+LAT onward. hi/lo hold old values while busy.
//  MULT: signed {hi,lo} = op1*op2 (2*WIDTH product). MULTU: unsigned.
//  DIV: signed, lo=quotient truncated toward zero, hi=remainder with sign of dividend. DIVU: unsigned.
//  Divide by zero: lo = all ones, hi = operand1 (both signed and unsigned).
//  Signed overflow (op1=MIN_INT, op2=-1): lo = MIN_INT, hi = 0.
//  MTHI/MTLO in IDLE: hi (resp. lo) <= operand1 at edge, busy stays 0, no latency.
//  start while busy: ignored entirely (controller is required to stall; no queueing).
//  md_op 0/7 with start: no effect.
//  flush in RUN: cnt<=0, busy<=0 next edge, pending discarded, hi/lo keep pre-op values.
//  flush and start same edge: flush wins; op not accepted, hi/lo unchanged (MTHI/MTLO also blocked).
//  flush in IDLE without start: no effect.
//  Counter width = $clog2(max(MUL_LAT,DIV_LAT)+1); no wrap possible.
//  hi/lo outputs are direct register outputs (no combinational path from inputs).
// TESTING
//  MULT op1=-3 op2=5 -> busy high 5 cycles; then hi=0xFFFFFFFF lo=0xFFFFFFF1.
//  MULTU op1=0xFFFFFFFF op2=2 -> after 5 cycles hi=0x00000001 lo=0xFFFFFFFE.
//  DIV op1=-7 op2=2 -> busy 10 cycles; lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF hi=7.
//  DIV 0x80000000/-1 -> lo=0x80000000 hi=0; MTHI 0x1234 in IDLE -> hi=0x1234 next cycle, busy=0.
//  MULT started, flush on 3rd busy cycle -> busy=0 next edge, hi/lo keep prior values; start during busy ignored.
//  reset low mid-DIV (cycle 4) -> busy=0, hi=lo=0 immediately; post-release MULT 2*3 -> lo=6 after 5 cycles.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the EX stage.
// Results are computed at issue and committed to HI/LO after a programmable busy latency.
module md_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    // Full {hi,lo} result of an arithmetic op, including the divide corner cases.
    function automatic logic [2*WIDTH-1:0] md_compute(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [2*WIDTH-1:0] sa_ext;
        logic signed [2*WIDTH-1:0] sb_ext;
        logic signed [WIDTH-1:0]   sa;
        logic signed [WIDTH-1:0]   sb;
        logic [WIDTH-1:0]          q;
        logic [WIDTH-1:0]          r;
        logic [2*WIDTH-1:0]        res;
        sa_ext = $signed({{WIDTH{a[WIDTH-1]}}, a});
        sb_ext = $signed({{WIDTH{b[WIDTH-1]}}, b});
        sa     = $signed(a);
        sb     = $signed(b);
        q      = '0;
        r      = '0;
        res    = '0;
        case (op)
            OP_MULT:  res = sa_ext * sb_ext;
            OP_MULTU: res = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
            OP_DIV: begin
                if (b == '0) begin
                    res = {a, ALL_ONES};
                end else if (a == MIN_INT && b == ALL_ONES) begin
                    res = {{WIDTH{1'b0}}, MIN_INT};
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r, q};
                end
            end
            OP_DIVU: begin
                if (b == '0) begin
                    res = {a, ALL_ONES};
                end else begin
                    q   = a / b;
                    r   = a % b;
                    res = {r, q};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0]   pend_lo_q, pend_lo_d;
    logic [2*WIDTH-1:0] result;

    assign result = md_compute(md_op, operand1, operand2);

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        // Flush kills both an in-flight op and any op offered on the same edge.
        if (flush) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE_CNT;
            if (cnt_q == ONE_CNT) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (start) begin
            case (md_op)
                OP_MULT, OP_MULTU: begin
                    {pend_hi_d, pend_lo_d} = result;
                    cnt_d = MUL_CNT;
                end
                OP_DIV, OP_DIVU: begin
                    {pend_hi_d, pend_lo_d} = result;
                    cnt_d = DIV_CNT;
                end
                OP_MTHI: hi_d = operand1;
                OP_MTLO: lo_d = operand1;
                default: ;
            endcase
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
